// File: rtl/proc_pkg.sv
// Shared constants for the ROM fetch sequencer: widths, FSM encoding, grant ids.
package proc_pkg;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 16;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_F_ISSUE = 3'd1;
   localparam logic [2:0] S_F_CAPT  = 3'd2;
   localparam logic [2:0] S_D_ISSUE = 3'd3;
   localparam logic [2:0] S_D_CAPT  = 3'd4;

   localparam logic GNT_FETCH = 1'b0;
   localparam logic GNT_DBG   = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to whoever was not granted last.
module rr_arb2
   import proc_pkg::*;
(
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (&req) begin
            if (last_grant == GNT_DBG) gnt[GNT_FETCH] = 1'b1;
            else                       gnt[GNT_DBG]   = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn)             last_grant <= GNT_DBG;
      else if (gnt[GNT_FETCH]) last_grant <= GNT_FETCH;
      else if (gnt[GNT_DBG])   last_grant <= GNT_DBG;
   end
endmodule

// File: rtl/rom_fetch_arbiter.sv
// Instruction fetch sequencer sharing the synchronous ROM port with a debug reader.
module rom_fetch_arbiter
   import proc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              fetch_req,
   output logic              fetch_ack,
   output logic [DATA_W-1:0] IR,
   output logic [ADDR_W-1:0] PC,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data,
   output logic              busy,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q
);
   logic [2:0] state;
   logic [1:0] gnt;
   logic [1:0] req_eff;

   // A request seen in its own ack cycle is the one just served, not a new one.
   assign req_eff = {dbg_req & ~dbg_ack, fetch_req & ~fetch_ack};

   rr_arb2 u_arb (
      .Clock  (Clock),
      .Resetn (Resetn),
      .en     (state == S_IDLE),
      .req    (req_eff),
      .gnt    (gnt)
   );

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state     <= S_IDLE;
         PC        <= '0;
         IR        <= '0;
         dbg_data  <= '0;
         rom_addr  <= '0;
         fetch_ack <= 1'b0;
         dbg_ack   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         fetch_ack <= 1'b0;
         dbg_ack   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt[GNT_FETCH]) begin
                  state    <= S_F_ISSUE;
                  rom_addr <= PC;
                  busy     <= 1'b1;
               end else if (gnt[GNT_DBG]) begin
                  state    <= S_D_ISSUE;
                  rom_addr <= dbg_addr;
                  busy     <= 1'b1;
               end
            end
            S_F_ISSUE: state <= S_F_CAPT;
            S_F_CAPT: begin
               IR        <= rom_q;
               fetch_ack <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            S_D_ISSUE: state <= S_D_CAPT;
            S_D_CAPT: begin
               dbg_data <= rom_q;
               dbg_ack  <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Jumps override the post-fetch increment; the fetch in flight keeps its address.
         if (pc_load)                PC <= pc_load_val;
         else if (state == S_F_CAPT) PC <= PC + ADDR_W'(1);
      end
   end
endmodule
